uart_tx_scheduler: RTL and testbench

- Shares the single UART transmitter between NUM_CH byte-stream requesters.
- Grants one requester per packet using round-robin arbitration, frames the packet and feeds bytes to the transmitter's tx_in/tx_en inputs, paced by its ready_to_send output.
- Frame format: SYNC_BYTE, channel ID, payload bytes, then an XOR checksum.

---
 rtl/uart_tx_scheduler.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that frames byte streams from NUM_CH requesters
// (SYNC, channel ID, payload, XOR checksum) onto a single UART transmitter.
module uart_tx_scheduler #(
  parameter int          NUM_CH    = 4,
  parameter int          MAX_LEN   = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     ch_valid,
  input  logic [8*NUM_CH-1:0]   ch_data,
  input  logic [NUM_CH-1:0]     ch_last,
  output logic [NUM_CH-1:0]     ch_ready,
  input  logic                  uart_ready_to_send,
  output logic [7:0]            uart_tx_in,
  output logic                  uart_tx_en,
  output logic                  busy,
  output logic [3:0]            active_ch
);

  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_ID, ST_DATA, ST_CSUM} frame_state_e;
  typedef enum logic [1:0] {PH_LOAD, PH_ISSUE, PH_WAIT_BUSY, PH_WAIT_DONE} phase_e;

  frame_state_e state_q;
  phase_e       phase_q;
  logic [7:0]   tx_in_q;
  logic         busy_q;
  logic [3:0]   active_ch_q;
  logic [3:0]   ptr_q;
  logic [7:0]   csum_q;
  logic [7:0]   cnt_q;
  logic         end_q;

  logic [15:0]  valid_pad_s;
  logic [15:0]  last_pad_s;
  logic [127:0] data_pad_s;
  logic         g_valid_s;
  logic         g_last_s;
  logic [7:0]   g_byte_s;
  logic         gnt_found_d;
  logic [3:0]   gnt_idx_d;
  logic [3:0]   ptr_d;
  logic         end_d;
  logic         fire_s;

  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // Pad the per-channel vectors to 16 channels so a 4-bit index always fits.
  assign valid_pad_s = 16'(ch_valid);
  assign last_pad_s  = 16'(ch_last);
  assign data_pad_s  = 128'(ch_data);
  assign g_valid_s   = valid_pad_s[active_ch_q];
  assign g_last_s    = last_pad_s[active_ch_q];
  assign g_byte_s    = data_pad_s[{active_ch_q, 3'b000} +: 8];

  assign uart_tx_in  = tx_in_q;
  assign uart_tx_en  = fire_s;
  assign busy        = busy_q;
  assign active_ch   = active_ch_q;

  // Round-robin search: first valid channel at or above the pointer, wrapping.
  always_comb begin
    int   cand;
    logic hit;
    gnt_found_d = 1'b0;
    gnt_idx_d   = 4'd0;
    cand        = 0;
    hit         = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand        = int'(ptr_q) + k;
      cand        = (cand >= NUM_CH) ? cand - NUM_CH : cand;
      hit         = !gnt_found_d && valid_pad_s[4'(cand)];
      gnt_idx_d   = hit ? 4'(cand) : gnt_idx_d;
      gnt_found_d = gnt_found_d | hit;
    end
  end

  // Send strobe and same-cycle payload handshake to the granted channel.
  always_comb begin
    fire_s   = (phase_q == PH_ISSUE) && uart_ready_to_send &&
               ((state_q != ST_DATA) || g_valid_s);
    ch_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_ready[i] = fire_s && (state_q == ST_DATA) && (active_ch_q == 4'(i));
    end
  end

  assign ptr_d = (active_ch_q == 4'(NUM_CH - 1)) ? 4'd0 : active_ch_q + 4'd1;
  assign end_d = g_last_s || (cnt_q == 8'(MAX_LEN - 1));

  // Frame FSM: frame state plus per-byte handshake phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_LOAD;
      tx_in_q     <= 8'h00;
      busy_q      <= 1'b0;
      active_ch_q <= 4'd0;
      ptr_q       <= 4'd0;
      csum_q      <= 8'h00;
      cnt_q       <= 8'd0;
      end_q       <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      phase_q <= PH_LOAD;
      if (gnt_found_d) begin
        active_ch_q <= gnt_idx_d;
        busy_q      <= 1'b1;
        csum_q      <= {4'b0000, gnt_idx_d};
        cnt_q       <= 8'd0;
        end_q       <= 1'b0;
        state_q     <= ST_SYNC;
      end
    end else begin
      case (phase_q)
        PH_LOAD: begin
          case (state_q)
            ST_SYNC: begin
              tx_in_q <= SYNC_BYTE;
              phase_q <= PH_ISSUE;
            end
            ST_ID: begin
              tx_in_q <= {4'b0000, active_ch_q};
              phase_q <= PH_ISSUE;
            end
            ST_DATA: begin
              if (g_valid_s) begin
                tx_in_q <= g_byte_s;
                phase_q <= PH_ISSUE;
              end
            end
            ST_CSUM: begin
              tx_in_q <= csum_q;
              phase_q <= PH_ISSUE;
            end
            default: state_q <= ST_IDLE;
          endcase
        end
        PH_ISSUE: begin
          if (fire_s) begin
            phase_q <= PH_WAIT_BUSY;
            if (state_q == ST_DATA) begin
              csum_q <= csum_fold(csum_q, tx_in_q);
              cnt_q  <= cnt_q + 8'd1;
              end_q  <= end_d;
            end
          end else if ((state_q == ST_DATA) && !g_valid_s) begin
            // Requester withdrew: go back and reload once it returns.
            phase_q <= PH_LOAD;
          end
        end
        PH_WAIT_BUSY: begin
          if (!uart_ready_to_send) begin
            phase_q <= PH_WAIT_DONE;
          end
        end
        PH_WAIT_DONE: begin
          if (uart_ready_to_send) begin
            phase_q <= PH_LOAD;
            case (state_q)
              ST_SYNC: state_q <= ST_ID;
              ST_ID:   state_q <= ST_DATA;
              ST_DATA: state_q <= end_q ? ST_CSUM : ST_DATA;
              ST_CSUM: begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                ptr_q   <= ptr_d;
              end
              default: state_q <= ST_IDLE;
            endcase
          end
        end
        default: phase_q <= PH_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: UART/requester models, a
// frame-level reference model, directed scenarios and randomized rounds.
module tb_uart_tx_scheduler;
  localparam int NCH  = 4;
  localparam int MAXL = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NCH-1:0]   ch_valid;
  logic [8*NCH-1:0] ch_data;
  logic [NCH-1:0]   ch_last;
  logic [NCH-1:0]   ch_ready;
  logic             uart_ready_to_send;
  logic [7:0]       uart_tx_in;
  logic             uart_tx_en;
  logic             busy;
  logic [3:0]       active_ch;

  logic rdy_q, force_busy;
  assign uart_ready_to_send = rdy_q && !force_busy;

  uart_tx_scheduler #(.NUM_CH(NCH), .MAX_LEN(MAXL), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_last(ch_last), .ch_ready(ch_ready), .uart_ready_to_send(uart_ready_to_send),
    .uart_tx_in(uart_tx_in), .uart_tx_en(uart_tx_en), .busy(busy), .active_ch(active_ch)
  );

  always #5 clk = ~clk;

  logic [8:0] chmem [NCH][256];
  int         chh [NCH];
  int         cht [NCH];
  logic [8:0] mmem [NCH][256];
  int         mh [NCH];
  int         mt [NCH];
  int         mptr;
  logic [7:0] cap [2048];
  logic [7:0] expv [2048];
  int         cap_n, exp_n;
  logic [NCH-1:0] hold, pend;
  int         txen_cnt, viol;
  int         rdy_cnt [NCH];
  int         drop_dly, rise_dly, drop_cd, rise_cd;
  int         chk_cnt, err_cnt;

  // UART transmitter model, requester drivers and protocol monitor.
  always @(negedge clk) begin
    logic           en_s, rts_s;
    logic [NCH-1:0] now_rdy;
    en_s    = uart_tx_en;
    rts_s   = uart_ready_to_send;
    now_rdy = ch_ready;
    if (en_s) begin
      txen_cnt++;
      if (!rts_s) viol++;
      if (cap_n < 2048) begin
        cap[cap_n] = uart_tx_in;
        cap_n++;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (now_rdy[i]) begin
        rdy_cnt[i]++;
        if (!en_s || !busy || active_ch != 4'(i)) viol++;
      end
    end
    if ($countones(now_rdy) > 1) viol++;
    if (drop_cd > 0) begin
      drop_cd--;
      if (drop_cd == 0) begin
        rdy_q   = 1'b0;
        rise_cd = rise_dly;
      end
    end else if (rise_cd > 0) begin
      rise_cd--;
      if (rise_cd == 0) rdy_q = 1'b1;
    end
    if (en_s) drop_cd = drop_dly;
    for (int i = 0; i < NCH; i++) begin
      if (pend[i] && chh[i] != cht[i]) chh[i]++;
    end
    pend = now_rdy;
    for (int i = 0; i < NCH; i++) begin
      if (chh[i] != cht[i] && !hold[i]) begin
        ch_valid[i]        = 1'b1;
        ch_data[8*i +: 8]  = chmem[i][chh[i]][7:0];
        ch_last[i]         = chmem[i][chh[i]][8];
      end else begin
        ch_valid[i]        = 1'b0;
        ch_data[8*i +: 8]  = 8'h00;
        ch_last[i]         = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    chk_cnt++;
    assert (obs === exp_v) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int ch, input logic [7:0] d, input logic last);
    chmem[ch][cht[ch]] = {last, d};
    cht[ch]++;
    mmem[ch][mt[ch]] = {last, d};
    mt[ch]++;
  endtask

  task automatic emit(input logic [7:0] b);
    expv[exp_n] = b;
    exp_n++;
  endtask

  // Reference: whole frames from the pending packets, round-robin from mptr.
  task automatic model_run();
    int         g, n;
    logic       found, done;
    logic [7:0] sum;
    logic [8:0] b;
    for (int f = 0; f < 256; f++) begin
      found = 1'b0;
      g     = 0;
      for (int k = 0; k < NCH; k++) begin
        if (!found && mh[(mptr + k) % NCH] != mt[(mptr + k) % NCH]) begin
          found = 1'b1;
          g     = (mptr + k) % NCH;
        end
      end
      if (!found) break;
      emit(8'hA5);
      emit(8'(g));
      sum  = 8'(g);
      n    = 0;
      done = 1'b0;
      while (!done && mh[g] != mt[g]) begin
        b = mmem[g][mh[g]];
        mh[g]++;
        emit(b[7:0]);
        sum = sum ^ b[7:0];
        n++;
        done = b[8] || (n == MAXL);
      end
      emit(sum);
      mptr = (g + 1) % NCH;
    end
  endtask

  function automatic logic all_empty();
    logic e;
    e = 1'b1;
    for (int i = 0; i < NCH; i++) e = e && (chh[i] == cht[i]);
    return e;
  endfunction

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (n < 20000 && !(all_empty() && !busy && uart_ready_to_send && cap_n == exp_n)) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_done_in_time"}, 32'(n < 20000), 32'd1);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, 32'(cap_n), 32'(exp_n));
    for (int i = 0; i < exp_n && i < cap_n; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), 32'(cap[i]), 32'(expv[i]));
    end
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    cap_n = 0;
    exp_n = 0;
  endtask

  task automatic wait_ready_pulse(input int ch, input string tag);
    int r0, n;
    r0 = rdy_cnt[ch];
    n  = 0;
    while (rdy_cnt[ch] == r0 && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_pulse_in_time"}, 32'(n < 5000), 32'd1);
  endtask

  initial begin
    int         t0, r0, any;
    logic [39:0] single_lit;
    logic [95:0] trunc_lit;
    single_lit = 40'hA5_01_11_22_32;
    trunc_lit  = 96'hA5_02_01_02_03_04_06_A5_02_05_06_01;
    chk_cnt = 0; err_cnt = 0; viol = 0; txen_cnt = 0;
    cap_n = 0; exp_n = 0; mptr = 0;
    for (int i = 0; i < NCH; i++) begin
      chh[i] = 0; cht[i] = 0; mh[i] = 0; mt[i] = 0; rdy_cnt[i] = 0;
    end
    hold = '0; pend = '0;
    drop_dly = 2; rise_dly = 20; drop_cd = 0; rise_cd = 0;
    rdy_q = 1'b1; force_busy = 1'b0;
    ch_valid = '0; ch_data = '0; ch_last = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_in", 32'(uart_tx_in), 32'd0);
    chk("rst_tx_en", 32'(uart_tx_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_active_ch", 32'(active_ch), 32'd0);
    chk("rst_ch_ready", 32'(ch_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Contention from pointer 0, then ch3 waits behind ch0.
    @(posedge clk); #2;
    push(0, 8'h00, 1'b1); push(2, 8'h02, 1'b1); push(3, 8'h03, 1'b1);
    model_run();
    wait_done("contention");
    check_stream("contention");
    @(posedge clk); #2;
    push(3, 8'h33, 1'b1); push(0, 8'h30, 1'b1);
    model_run();
    wait_done("behind_ch0");
    check_stream("behind_ch0");

    // Single channel lossless frame.
    @(posedge clk); #2;
    t0 = txen_cnt; r0 = rdy_cnt[1];
    push(1, 8'h11, 1'b0); push(1, 8'h22, 1'b1);
    model_run();
    wait_done("single");
    for (int i = 0; i < 5; i++) chk($sformatf("single_lit%0d", i), 32'(cap[i]), 32'(single_lit[8*(4-i) +: 8]));
    chk("single_txen_pulses", 32'(txen_cnt - t0), 32'd5);
    chk("single_ready_pulses", 32'(rdy_cnt[1] - r0), 32'd2);
    check_stream("single");

    // Reset in DATA WAIT_BUSY; pointer (now 2) must return to 0.
    @(posedge clk); #2;
    push(2, 8'h10, 1'b0); push(2, 8'h20, 1'b0); push(2, 8'h30, 1'b1);
    wait_ready_pulse(2, "midrst");
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("midrst_tx_in", 32'(uart_tx_in), 32'd0);
    chk("midrst_tx_en", 32'(uart_tx_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_active_ch", 32'(active_ch), 32'd0);
    chk("midrst_ch_ready", 32'(ch_ready), 32'd0);
    for (int i = 0; i < NCH; i++) begin
      chh[i] = cht[i]; mh[i] = mt[i];
    end
    pend = '0; hold = '0; cap_n = 0; exp_n = 0; mptr = 0;
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #2;
    push(1, 8'h5A, 1'b1); push(3, 8'hC3, 1'b0); push(3, 8'h3C, 1'b1);
    model_run();
    wait_done("after_rst");
    check_stream("after_rst");

    // Truncation at MAX_LEN = 4.
    @(posedge clk); #2;
    for (int b = 1; b <= 6; b++) push(2, 8'(b), b == 6);
    model_run();
    wait_done("trunc");
    for (int i = 0; i < 12; i++) chk($sformatf("trunc_lit%0d", i), 32'(cap[i]), 32'(trunc_lit[8*(11-i) +: 8]));
    check_stream("trunc");

    // Requester stalls 50 cycles after its first payload byte.
    @(posedge clk); #2;
    push(0, 8'h40, 1'b0); push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b1);
    model_run();
    wait_ready_pulse(0, "stall");
    hold[0] = 1'b1;
    t0 = txen_cnt; r0 = rdy_cnt[0];
    repeat (50) @(negedge clk);
    #1;
    chk("stall_no_txen", 32'(txen_cnt - t0), 32'd0);
    chk("stall_no_ready", 32'(rdy_cnt[0] - r0), 32'd0);
    chk("stall_busy", 32'(busy), 32'd1);
    hold[0] = 1'b0;
    wait_done("stall");
    check_stream("stall");

    // Transmitter busy for 30 cycles around the grant.
    @(posedge clk); #2;
    force_busy = 1'b1;
    push(3, 8'h77, 1'b1);
    model_run();
    t0 = txen_cnt;
    repeat (30) @(posedge clk);
    #2;
    chk("busytx_no_txen", 32'(txen_cnt - t0), 32'd0);
    chk("busytx_busy", 32'(busy), 32'd1);
    chk("busytx_active_ch", 32'(active_ch), 32'd3);
    force_busy = 1'b0;
    #1;
    chk("busytx_first_txen", 32'(uart_tx_en), 32'd1);
    chk("busytx_first_byte", 32'(uart_tx_in), 32'hA5);
    wait_done("busytx");
    check_stream("busytx");

    // Randomized rounds of simultaneous multi-channel packets.
    for (int r = 0; r < 4; r++) begin
      @(posedge clk); #2;
      drop_dly = int'($urandom_range(1, 3));
      rise_dly = int'($urandom_range(3, 12));
      any = 0;
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 1) == 1) begin
          any = 1;
          for (int p = 0; p < int'($urandom_range(1, 2)); p++) begin
            int len;
            len = int'($urandom_range(1, 6));
            for (int b = 0; b < len; b++) push(c, 8'($urandom), b == len - 1);
          end
        end
      end
      if (any == 0) push(r % NCH, 8'($urandom), 1'b1);
      model_run();
      wait_done($sformatf("rand%0d", r));
      check_stream($sformatf("rand%0d", r));
    end

    chk("protocol_violations", 32'(viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
